ifetch_ctrl: RTL and testbench

//  Fetch-stage sequencer for the 32-bit instruction ROM of the pipeline CPU. Owns the PC

---
 rtl/ifetch_ctrl_pkg.sv | 27 ++
 rtl/ifetch_ctrl_if.sv | 31 +++
 rtl/ifetch_ctrl_npc.sv | 39 +++
 rtl/ifetch_ctrl.sv | 77 +++++++
 tb/tb_ifetch_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// Shared constants, state encoding and IF/ID latch layout for the instruction-fetch stage.
// Every ifetch_ctrl file imports this package.
package ifetch_ctrl_pkg;

   localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
   localparam logic [31:0] ROM_BASE_DEF   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
   localparam int unsigned ROM_WORDS_DEF  = 4096;
   localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic        valid;
      logic        fault;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{instr: NOP_WORD, pc: 32'h0, pc8: 32'h0,
                                     valid: 1'b0, fault: 1'b0};

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-stage bundle: control requests in, ROM address/data, and the IF/ID latch outputs.
// The master side is the fetch controller; the slave side is its environment.
interface ifetch_ctrl_if;

   logic        stall;
   logic        flush;
   logic        br_valid;
   logic [31:0] br_target;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic [31:0] rom_d;
   logic [31:0] pc_now;
   logic        rom_sel;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc8;
   logic        ifid_valid;
   logic        ifid_fault;

   modport master (
      input  stall, flush, br_valid, br_target, exc_req, eret_req, epc, rom_d,
      output pc_now, rom_sel, ifid_instr, ifid_pc, ifid_pc8, ifid_valid, ifid_fault
   );

   modport slave (
      output stall, flush, br_valid, br_target, exc_req, eret_req, epc, rom_d,
      input  pc_now, rom_sel, ifid_instr, ifid_pc, ifid_pc8, ifid_valid, ifid_fault
   );

endinterface

// File: rtl/ifetch_ctrl_npc.sv
// Combinational next-PC priority mux and ROM address-range/alignment check.
module ifetch_ctrl_npc
   import ifetch_ctrl_pkg::*;
#(
   parameter logic [31:0] ROM_BASE   = ROM_BASE_DEF,
   parameter int unsigned ROM_WORDS  = ROM_WORDS_DEF,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic [31:0] pc_now,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic [31:0] epc,
   output logic [31:0] pc_next,
   output logic        addr_ok
);

   // The range check is 33 bits wide so a ROM that ends exactly at 2^32 cannot wrap.
   localparam logic [32:0] ROM_LO = {1'b0, ROM_BASE};
   localparam logic [32:0] ROM_HI = ROM_LO + (33'(ROM_WORDS) << 2);

   always_comb begin
      addr_ok = (pc_now[1:0] == 2'b00)
             && ({1'b0, pc_now} >= ROM_LO)
             && ({1'b0, pc_now} <  ROM_HI);
   end

   // exc/eret beat stall; a branch under stall is dropped, and ID re-asserts it later.
   always_comb begin
      if (exc_req)       pc_next = EXC_VECTOR;
      else if (eret_req) pc_next = epc;
      else if (stall)    pc_next = pc_now;
      else if (br_valid) pc_next = br_target;
      else               pc_next = pc_now + 32'd4;
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, the BOOT/RUN FSM and the IF/ID latch, and drives
// the ROM select.
module ifetch_ctrl
   import ifetch_ctrl_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
   parameter logic [31:0] ROM_BASE   = ROM_BASE_DEF,
   parameter int unsigned ROM_WORDS  = ROM_WORDS_DEF,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic          clk,
   input  logic          reset,
   ifetch_ctrl_if.master bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d, pc_next;
   logic         addr_ok;
   ifid_t        ifid_q, ifid_d;

   ifetch_ctrl_npc #(
      .ROM_BASE   (ROM_BASE),
      .ROM_WORDS  (ROM_WORDS),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_npc (
      .pc_now    (pc_q),
      .exc_req   (bus.exc_req),
      .eret_req  (bus.eret_req),
      .stall     (bus.stall),
      .br_valid  (bus.br_valid),
      .br_target (bus.br_target),
      .epc       (bus.epc),
      .pc_next   (pc_next),
      .addr_ok   (addr_ok)
   );

   // NOTE: every always_comb output is given a default first so no path infers a latch.
   always_comb begin
      state_d = RUN;
      pc_d    = pc_q;
      ifid_d  = ifid_q;
      if (state_q == RUN) begin
         pc_d = pc_next;
         if (bus.exc_req || bus.eret_req || bus.flush) begin
            ifid_d = IFID_BUBBLE;
         end else if (!bus.stall) begin
            ifid_d = '{instr: (addr_ok ? bus.rom_d : NOP_WORD),
                       pc:    pc_q,
                       pc8:   pc_q + 32'd8,
                       valid: 1'b1,
                       fault: ~addr_ok};
         end
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= PC_RESET;
         ifid_q  <= IFID_BUBBLE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
      end
   end

   assign bus.pc_now     = pc_q;
   assign bus.rom_sel    = (state_q == RUN) && addr_ok;
   assign bus.ifid_instr = ifid_q.instr;
   assign bus.ifid_pc    = ifid_q.pc;
   assign bus.ifid_pc8   = ifid_q.pc8;
   assign bus.ifid_valid = ifid_q.valid;
   assign bus.ifid_fault = ifid_q.fault;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: reset, straight-line fetch, redirects, exception/eret,
// faulting fetches, flush, and reset in the middle of a run.
module tb_ifetch_ctrl;

   localparam logic [31:0] TAG = 32'hDEAD_0000;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   ifetch_ctrl_if bus ();

   ifetch_ctrl u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: the word at a given address is that address XOR a tag; it drives 0 when not selected.
   always_comb bus.rom_d = bus.rom_sel ? (bus.pc_now ^ TAG) : 32'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall     = 1'b0;
      bus.flush     = 1'b0;
      bus.br_valid  = 1'b0;
      bus.br_target = 32'h0;
      bus.exc_req   = 1'b0;
      bus.eret_req  = 1'b0;
      bus.epc       = 32'h0;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic valid, input logic fault);
      check({tag, ".pc"},    bus.ifid_pc,    pc);
      check({tag, ".pc8"},   bus.ifid_pc8,   (pc == 32'h0 && !valid) ? 32'h0 : pc + 32'd8);
      check({tag, ".instr"}, bus.ifid_instr, instr);
      check({tag, ".valid"}, 32'(bus.ifid_valid), 32'(valid));
      check({tag, ".fault"}, 32'(bus.ifid_fault), 32'(fault));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();

      // Reset held for three cycles.
      reset = 1'b1;
      repeat (3) tick();
      check("rst.pc", bus.pc_now, 32'h3000);
      check("rst.sel", 32'(bus.rom_sel), 32'd0);
      check_ifid("rst", 32'h0, 32'h0, 1'b0, 1'b0);

      reset = 1'b0;
      check("boot.sel", 32'(bus.rom_sel), 32'd0);
      check("boot.valid", 32'(bus.ifid_valid), 32'd0);
      tick();
      check("run0.pc", bus.pc_now, 32'h3000);
      check("run0.sel", 32'(bus.rom_sel), 32'd1);
      check("run0.valid", 32'(bus.ifid_valid), 32'd0);

      // Straight-line fetch: four consecutive words, no gaps.
      for (int i = 0; i < 4; i++) begin
         tick();
         check_ifid("seq", 32'h3000 + 32'(4 * i), (32'h3000 + 32'(4 * i)) ^ TAG, 1'b1, 1'b0);
         check("seq.pcnow", bus.pc_now, 32'h3004 + 32'(4 * i));
      end

      // Exception under stall at pc 0x3010, then eret back to 0x3014.
      bus.exc_req = 1'b1;
      bus.stall   = 1'b1;
      tick();
      check("exc.pc", bus.pc_now, 32'h4180);
      check_ifid("exc", 32'h0, 32'h0, 1'b0, 1'b0);
      idle_inputs();
      bus.eret_req = 1'b1;
      bus.epc      = 32'h3014;
      tick();
      check("eret.pc", bus.pc_now, 32'h3014);
      check("eret.valid", 32'(bus.ifid_valid), 32'd0);
      idle_inputs();
      tick();
      check("eret+1.pc", bus.pc_now, 32'h3018);
      check_ifid("eret+1", 32'h3014, 32'h3014 ^ TAG, 1'b1, 1'b0);

      // A branch under stall is dropped; the same branch without stall redirects.
      bus.stall     = 1'b1;
      bus.br_valid  = 1'b1;
      bus.br_target = 32'h3100;
      tick();
      check("brstall.pc", bus.pc_now, 32'h3018);
      check_ifid("brstall", 32'h3014, 32'h3014 ^ TAG, 1'b1, 1'b0);
      bus.stall = 1'b0;
      tick();
      check("br.pc", bus.pc_now, 32'h3100);
      check_ifid("br", 32'h3018, 32'h3018 ^ TAG, 1'b1, 1'b0);
      idle_inputs();
      tick();
      check("br+1.pc", bus.pc_now, 32'h3104);
      check_ifid("br+1", 32'h3100, 32'h3100 ^ TAG, 1'b1, 1'b0);

      // Misaligned target, then a target past the end of the ROM.
      bus.br_valid  = 1'b1;
      bus.br_target = 32'h3002;
      tick();
      check("mis.pc", bus.pc_now, 32'h3002);
      check("mis.sel", 32'(bus.rom_sel), 32'd0);
      bus.br_target = 32'h7000;
      tick();
      check("oor.pc", bus.pc_now, 32'h7000);
      check("oor.sel", 32'(bus.rom_sel), 32'd0);
      check_ifid("mis", 32'h3002, 32'h0, 1'b1, 1'b1);
      idle_inputs();
      tick();
      check("oor+1.pc", bus.pc_now, 32'h7004);
      check_ifid("oor", 32'h7000, 32'h0, 1'b1, 1'b1);

      // Last ROM word is in range.
      bus.br_valid  = 1'b1;
      bus.br_target = 32'h6FFC;
      tick();
      check("last.sel", 32'(bus.rom_sel), 32'd1);
      idle_inputs();
      tick();
      check_ifid("last", 32'h6FFC, 32'h6FFC ^ TAG, 1'b1, 1'b0);
      check("last+1.pc", bus.pc_now, 32'h7000);

      // Flush alone, then flush together with stall.
      bus.flush = 1'b1;
      tick();
      check("flush.pc", bus.pc_now, 32'h7004);
      check_ifid("flush", 32'h0, 32'h0, 1'b0, 1'b0);
      bus.stall = 1'b1;
      tick();
      check("flstall.pc", bus.pc_now, 32'h7004);
      check_ifid("flstall", 32'h0, 32'h0, 1'b0, 1'b0);
      idle_inputs();

      // Walk to 0x3040, then reset with a pending branch.
      bus.br_valid  = 1'b1;
      bus.br_target = 32'h303C;
      tick();
      idle_inputs();
      tick();
      check("pre.pc", bus.pc_now, 32'h3040);
      reset         = 1'b1;
      bus.br_valid  = 1'b1;
      bus.br_target = 32'h3100;
      tick();
      check("mrst.pc", bus.pc_now, 32'h3000);
      check("mrst.sel", 32'(bus.rom_sel), 32'd0);
      check_ifid("mrst", 32'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b0;
      idle_inputs();
      tick();
      check("mrst.run.pc", bus.pc_now, 32'h3000);
      check("mrst.run.sel", 32'(bus.rom_sel), 32'd1);
      tick();
      check_ifid("mrst.run", 32'h3000, 32'h3000 ^ TAG, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
